// File: rtl/hamming_pkg.sv
// Shared types and constants for the Hamming scrub sequencer.
package hamming_pkg;
  localparam int WIDTH       = 16;
  localparam int BLOCKS      = WIDTH / 4;
  localparam int PARITY_BITS = BLOCKS * 3;

  typedef enum logic [2:0] {
    ST_IDLE, ST_COUNT, ST_ENCODE, ST_HOLD,
    ST_CHECK, ST_CORRECT, ST_VERIFY, ST_FAULT
  } state_t;

  // One flag per nibble block: set when that block's 3 syndrome bits are nonzero.
  function automatic logic [BLOCKS-1:0] syn_block_nz(input logic [PARITY_BITS-1:0] syn);
    logic [BLOCKS-1:0] r;
    for (int i = 0; i < BLOCKS; i++) r[i] = |syn[3*i +: 3];
    return r;
  endfunction
endpackage

// File: rtl/hamming_scrub_timer.sv
// Scrub interval down-counter: load wins, decrement stops at zero, otherwise holds.
module scrub_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);
  logic [W-1:0] cnt_q, cnt_d;

  // Next count.
  always_comb begin
    cnt_d = cnt_q;
    if (load)                    cnt_d = load_val;
    else if (dec && cnt_q != '0) cnt_d = cnt_q - W'(1);
  end

  // Count register, cleared to zero on reset.
  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);
endmodule

// File: rtl/hamming_scrub_ctrl.sv
// Host/scrub sequencer for the Hamming-protected counter datapath.
module hamming_scrub_ctrl
  import hamming_pkg::*;
#(
  parameter int TIMER_W  = 16,
  parameter int SETTLE   = 1,
  parameter int ERRCNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   count_req,
  input  logic                   scrub_en,
  input  logic [TIMER_W-1:0]     scrub_period,
  input  logic                   clear_fault,
  input  logic [PARITY_BITS-1:0] dp_syndrome,
  output logic                   count_grant,
  output logic                   dp_enable,
  output logic                   dp_encode,
  output logic                   dp_check,
  output logic                   dp_correct,
  output logic                   busy,
  output logic [BLOCKS-1:0]      err_block,
  output logic                   err_corrected,
  output logic [ERRCNT_W-1:0]    err_count,
  output logic                   fault
);
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t              state_q, state_d;
  logic [CW-1:0]       settle_q, settle_d;
  logic [BLOCKS-1:0]   err_block_q, err_block_d;
  logic [ERRCNT_W-1:0] err_count_q, err_count_d;
  logic                err_corr_q, err_corr_d;
  logic                t_load, t_dec, t_zero, settle_last;
  logic [TIMER_W-1:0]  t_val;

  // A zero period would never count down meaningfully; treat it as 1.
  assign t_val       = (scrub_period == '0) ? TIMER_W'(1) : scrub_period;
  assign settle_last = (settle_q == CW'(SETTLE - 1));

  scrub_timer #(.W(TIMER_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .load_val (t_val),
    .dec      (t_dec),
    .zero     (t_zero)
  );

  // Sequencer next-state, timer control and status updates.
  always_comb begin
    state_d     = state_q;
    settle_d    = '0;
    err_block_d = err_block_q;
    err_count_d = err_count_q;
    err_corr_d  = 1'b0;
    t_load      = 1'b0;
    t_dec       = 1'b0;
    case (state_q)
      ST_IDLE:   if (count_req) state_d = ST_COUNT;
      ST_COUNT:  if (!count_req) state_d = ST_ENCODE;
      ST_ENCODE: begin
        t_load  = 1'b1;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        // Host request beats a due scrub; deferred requests land here too.
        if (count_req)   state_d = ST_COUNT;
        else if (scrub_en) begin
          if (t_zero) state_d = ST_CHECK;
          else        t_dec   = 1'b1;
        end
      end
      ST_CHECK: begin
        if (settle_last) begin
          err_block_d = syn_block_nz(dp_syndrome);
          if (dp_syndrome == '0) begin
            state_d = ST_HOLD;
            t_load  = 1'b1;
          end else begin
            state_d = ST_CORRECT;
          end
        end else begin
          settle_d = settle_q + CW'(1);
        end
      end
      ST_CORRECT: state_d = ST_VERIFY;
      ST_VERIFY: begin
        if (settle_last) begin
          if (dp_syndrome == '0) begin
            err_corr_d = 1'b1;
            if (err_count_q != '1) err_count_d = err_count_q + ERRCNT_W'(1);
            state_d = ST_HOLD;
            t_load  = 1'b1;
          end else begin
            state_d = ST_FAULT;
          end
        end else begin
          settle_d = settle_q + CW'(1);
        end
      end
      ST_FAULT:  if (clear_fault) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State and status registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      settle_q    <= '0;
      err_block_q <= '0;
      err_count_q <= '0;
      err_corr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      err_block_q <= err_block_d;
      err_count_q <= err_count_d;
      err_corr_q  <= err_corr_d;
    end
  end

  assign dp_enable     = (state_q == ST_COUNT);
  assign count_grant   = (state_q == ST_COUNT);
  assign dp_encode     = (state_q == ST_ENCODE);
  assign dp_check      = (state_q == ST_CHECK) || (state_q == ST_VERIFY);
  assign dp_correct    = (state_q == ST_CORRECT);
  assign busy          = (state_q == ST_CHECK) || (state_q == ST_CORRECT) || (state_q == ST_VERIFY);
  assign fault         = (state_q == ST_FAULT);
  assign err_block     = err_block_q;
  assign err_count     = err_count_q;
  assign err_corrected = err_corr_q;
endmodule

// File: tb/tb_hamming_scrub_ctrl.sv
// Directed bench for hamming_scrub_ctrl: vector table plus multi-cycle sequences.
module tb_hamming_scrub_ctrl;
  logic        clk = 1'b0;
  logic        rst, count_req, scrub_en, clear_fault;
  logic [15:0] scrub_period;
  logic [11:0] dp_syndrome;
  logic        count_grant, dp_enable, dp_encode, dp_check, dp_correct, busy;
  logic [3:0]  err_block;
  logic        err_corrected, fault;
  logic [7:0]  err_count;

  int errors = 0;
  int checks = 0;

  hamming_scrub_ctrl dut (
    .clk(clk), .rst(rst), .count_req(count_req), .scrub_en(scrub_en),
    .scrub_period(scrub_period), .clear_fault(clear_fault), .dp_syndrome(dp_syndrome),
    .count_grant(count_grant), .dp_enable(dp_enable), .dp_encode(dp_encode),
    .dp_check(dp_check), .dp_correct(dp_correct), .busy(busy), .err_block(err_block),
    .err_corrected(err_corrected), .err_count(err_count), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       req, sen, clr;
    logic [11:0] syn;
    logic       en, enc, chk, cor, bsy, flt, ecr;
    logic [3:0] eblk;
    logic [7:0] ecnt;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic req, sen, clr, input logic [11:0] syn,
                     input logic en, enc, chk, cor, bsy, flt, ecr,
                     input logic [3:0] eblk, input logic [7:0] ecnt);
    vec_t v;
    v.req = req; v.sen = sen; v.clr = clr; v.syn = syn;
    v.en = en; v.enc = enc; v.chk = chk; v.cor = cor; v.bsy = bsy;
    v.flt = flt; v.ecr = ecr; v.eblk = eblk; v.ecnt = ecnt;
    vt.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [19:0] outs();
    return {dp_enable, count_grant, dp_encode, dp_check, dp_correct, busy,
            fault, err_corrected, err_block, err_count};
  endfunction

  task automatic do_reset();
    rst = 1'b0; count_req = 1'b0; clear_fault = 1'b0; dp_syndrome = '0;
    step(); step();
    rst = 1'b1;
  endtask

  // Wait in HOLD until a scrub starts; false on timeout.
  task automatic wait_check(output bit ok);
    int w = 0;
    while (!dp_check && w < 40) begin step(); w++; end
    ok = dp_check;
  endtask

  initial begin
    bit ok;
    int n, last, cor_seen;
    int gaps[$];

    scrub_en = 1'b1; scrub_period = 16'd2;
    do_reset();
    chk("reset_outs", 32'(outs()), 32'h0);

    // req sen clr syn | en enc chk cor bsy flt ecr eblk ecnt
    add(1,1,0,12'h000, 1,0,0,0,0,0,0, 4'h0, 8'd0); // COUNT
    add(0,1,0,12'h000, 0,1,0,0,0,0,0, 4'h0, 8'd0); // ENCODE
    add(0,1,0,12'h000, 0,0,0,0,0,0,0, 4'h0, 8'd0); // HOLD t=2
    add(0,1,0,12'h000, 0,0,0,0,0,0,0, 4'h0, 8'd0); // HOLD t=1
    add(0,1,0,12'h000, 0,0,0,0,0,0,0, 4'h0, 8'd0); // HOLD t=0
    add(0,1,0,12'h000, 0,0,1,0,1,0,0, 4'h0, 8'd0); // CHECK
    add(0,1,0,12'h003, 0,0,0,1,1,0,0, 4'h1, 8'd0); // CORRECT, block 0 flagged
    add(0,1,0,12'h003, 0,0,1,0,1,0,0, 4'h1, 8'd0); // VERIFY
    add(0,1,0,12'h000, 0,0,0,0,0,0,1, 4'h1, 8'd1); // HOLD, corrected
    add(0,1,0,12'h000, 0,0,0,0,0,0,0, 4'h1, 8'd1); // HOLD t=1
    add(0,1,0,12'h000, 0,0,0,0,0,0,0, 4'h1, 8'd1); // HOLD t=0
    add(0,1,0,12'h000, 0,0,1,0,1,0,0, 4'h1, 8'd1); // CHECK
    add(0,1,0,12'h030, 0,0,0,1,1,0,0, 4'h2, 8'd1); // CORRECT, block 1 flagged
    add(0,1,0,12'h030, 0,0,1,0,1,0,0, 4'h2, 8'd1); // VERIFY
    add(0,1,0,12'h030, 0,0,0,0,0,1,0, 4'h2, 8'd1); // FAULT
    add(1,1,0,12'h000, 0,0,0,0,0,1,0, 4'h2, 8'd1); // count_req ignored
    add(0,1,1,12'h000, 0,0,0,0,0,0,0, 4'h2, 8'd1); // cleared -> IDLE
    add(1,1,0,12'h000, 1,0,0,0,0,0,0, 4'h2, 8'd1); // COUNT
    add(0,1,0,12'h000, 0,1,0,0,0,0,0, 4'h2, 8'd1); // ENCODE
    add(0,1,0,12'h000, 0,0,0,0,0,0,0, 4'h2, 8'd1); // HOLD t=2
    add(0,1,0,12'h000, 0,0,0,0,0,0,0, 4'h2, 8'd1); // HOLD t=1
    add(0,1,0,12'h000, 0,0,0,0,0,0,0, 4'h2, 8'd1); // HOLD t=0
    add(1,1,0,12'h000, 1,0,0,0,0,0,0, 4'h2, 8'd1); // request beats scrub
    add(0,1,0,12'h000, 0,1,0,0,0,0,0, 4'h2, 8'd1); // ENCODE
    add(0,1,0,12'h000, 0,0,0,0,0,0,0, 4'h2, 8'd1); // HOLD t=2
    add(0,1,0,12'h000, 0,0,0,0,0,0,0, 4'h2, 8'd1); // HOLD t=1
    add(0,1,0,12'h000, 0,0,0,0,0,0,0, 4'h2, 8'd1); // HOLD t=0
    add(0,1,0,12'h000, 0,0,1,0,1,0,0, 4'h2, 8'd1); // CHECK
    add(1,1,0,12'h000, 0,0,0,0,0,0,0, 4'h0, 8'd1); // clean, request deferred
    add(1,1,0,12'h000, 1,0,0,0,0,0,0, 4'h0, 8'd1); // granted after scrub
    add(0,1,0,12'h000, 0,1,0,0,0,0,0, 4'h0, 8'd1); // ENCODE
    add(0,1,0,12'h000, 0,0,0,0,0,0,0, 4'h0, 8'd1); // HOLD t=2
    add(0,0,0,12'h000, 0,0,0,0,0,0,0, 4'h0, 8'd1); // frozen
    add(0,0,0,12'h000, 0,0,0,0,0,0,0, 4'h0, 8'd1);
    add(0,0,0,12'h000, 0,0,0,0,0,0,0, 4'h0, 8'd1);
    add(0,0,0,12'h000, 0,0,0,0,0,0,0, 4'h0, 8'd1);
    add(0,1,0,12'h000, 0,0,0,0,0,0,0, 4'h0, 8'd1); // HOLD t=1
    add(0,1,0,12'h000, 0,0,0,0,0,0,0, 4'h0, 8'd1); // HOLD t=0
    add(0,1,0,12'h000, 0,0,1,0,1,0,0, 4'h0, 8'd1); // CHECK
    add(0,1,0,12'h000, 0,0,0,0,0,0,0, 4'h0, 8'd1); // HOLD

    foreach (vt[i]) begin
      count_req = vt[i].req; scrub_en = vt[i].sen;
      clear_fault = vt[i].clr; dp_syndrome = vt[i].syn;
      step();
      chk($sformatf("vec%0d", i), 32'(outs()),
          32'({vt[i].en, vt[i].en, vt[i].enc, vt[i].chk, vt[i].cor, vt[i].bsy,
               vt[i].flt, vt[i].ecr, vt[i].eblk, vt[i].ecnt}));
    end
    count_req = 1'b0; clear_fault = 1'b0; dp_syndrome = '0; scrub_en = 1'b1;

    // Reset while in CORRECT aborts the scrub and clears everything.
    wait_check(ok);
    if (!ok) begin errors++; checks++; $display("FAIL rstcor_timeout: no dp_check"); end
    dp_syndrome = 12'h001;
    step();
    chk("rstcor_in_correct", 32'(dp_correct), 32'h1);
    dp_syndrome = '0; rst = 1'b0;
    step();
    chk("rstcor_outs", 32'(outs()), 32'h0);
    rst = 1'b1;

    // Periodic scrubs with period 4: one dp_check every 5+SETTLE cycles.
    scrub_period = 16'd4;
    count_req = 1'b1; step(); count_req = 1'b0; step(); step();
    n = 0; last = -1; cor_seen = 0;
    for (int c = 0; c < 60 && n < 3; c++) begin
      step();
      if (dp_correct) cor_seen++;
      if (dp_check) begin
        if (last >= 0) gaps.push_back(c - last);
        last = c; n++;
      end
    end
    chk("period_scrubs_seen", 32'(n), 32'd3);
    foreach (gaps[i]) chk($sformatf("period_gap%0d", i), 32'(gaps[i]), 32'd6);
    chk("period_no_correct", 32'(cor_seen), 32'd0);
    chk("period_errcnt", 32'(err_count), 32'd0);

    // Saturation: 256 successful corrections leave err_count at all-ones.
    scrub_period = 16'd1;
    for (int k = 0; k < 256; k++) begin
      wait_check(ok);
      if (!ok) begin
        errors++; checks++;
        $display("FAIL sat_timeout: iteration %0d no dp_check", k);
        break;
      end
      dp_syndrome = 12'h100; step();
      dp_syndrome = '0; step();
      step();
      if (k == 254) chk("sat_255", 32'(err_count), 32'hFF);
    end
    chk("sat_256", 32'(err_count), 32'hFF);
    chk("sat_no_fault", 32'(fault), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
